// File: rtl/nonce_sweep_ctrl.sv
// Drives one compression engine across a run of nonces, writes each H0 to memory
// and keeps the smallest H0 seen together with the nonce that produced it.
module nonce_sweep_ctrl #(
  parameter int NW      = 7,
  parameter int AW      = 16,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [31:0]   base_nonce,
  input  logic [NW-1:0] num_nonces,
  input  logic [AW-1:0] out_base,
  output logic          eng_clr,
  output logic          eng_on,
  output logic [31:0]   eng_nonce,
  input  logic          eng_finished,
  input  logic [31:0]   eng_h0,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [31:0]   best_nonce,
  output logic [31:0]   best_h0
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_WRITE, S_DONE} state_t;

  state_t        state;
  logic [NW-1:0] idx;
  logic [NW-1:0] num_q;
  logic [31:0]   base_q;
  logic [AW-1:0] out_base_q;
  logic [CW-1:0] cnt;

  assign busy = (state != S_IDLE);

  // mem_wdata doubles as the captured H0; it is held unchanged through WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      num_q       <= '0;
      base_q      <= '0;
      out_base_q  <= '0;
      cnt         <= '0;
      eng_clr     <= 1'b0;
      eng_on      <= 1'b0;
      eng_nonce   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      best_nonce  <= '0;
      best_h0     <= '1;
    end else begin
      eng_clr <= 1'b0;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q      <= base_nonce;
            num_q       <= num_nonces;
            out_base_q  <= out_base;
            idx         <= '0;
            timeout_err <= 1'b0;
            best_h0     <= '1;
            best_nonce  <= '0;
            if (num_nonces == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              eng_clr   <= 1'b1;
              eng_nonce <= base_nonce;
              state     <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          eng_on <= 1'b1;
          cnt    <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          // finished takes priority over a timeout landing on the same cycle
          if (eng_finished) begin
            eng_on    <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= out_base_q + AW'(idx);
            mem_wdata <= eng_h0;
            state     <= S_WRITE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            eng_on      <= 1'b0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WRITE: begin
          if (mem_wdata < best_h0) begin
            best_h0    <= mem_wdata;
            best_nonce <= eng_nonce;
          end
          if (idx == num_q - NW'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx       <= idx + NW'(1);
            eng_clr   <= 1'b1;
            eng_nonce <= base_q + 32'(idx) + 32'd1;
            state     <= S_CLEAR;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          eng_on <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: behavioural engine, scoreboard of expected writes and
// clear-nonces, a table of sweeps, plus hand sequences for start-while-busy and reset.
module tb_nonce_sweep_ctrl;
  localparam int NW = 7;
  localparam int AW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [31:0]   base_nonce;
  logic [NW-1:0] num_nonces;
  logic [AW-1:0] out_base;
  logic          eng_clr, eng_on, eng_finished;
  logic [31:0]   eng_nonce, eng_h0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, timeout_err;
  logic [31:0]   best_nonce, best_h0;

  nonce_sweep_ctrl #(.NW(NW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_nonce(base_nonce),
    .num_nonces(num_nonces), .out_base(out_base), .eng_clr(eng_clr), .eng_on(eng_on),
    .eng_nonce(eng_nonce), .eng_finished(eng_finished), .eng_h0(eng_h0),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .timeout_err(timeout_err), .best_nonce(best_nonce), .best_h0(best_h0)
  );

  always #5 clk = ~clk;

  // Engine model: finished after lat counted eng_on cycles, or never when hang is set.
  int lat  = 0;
  int mode = 0;
  bit hang = 1'b0;
  int ecnt;

  function automatic logic [31:0] h0f(input int m, input logic [31:0] n);
    case (m)
      0:       return ~n;
      1:       return 32'h0000_1234;
      default: return n ^ 32'h0000_0002;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 ecnt <= 0;
    else if (eng_clr)             ecnt <= 0;
    else if (eng_on && ecnt < lat) ecnt <= ecnt + 1;
  end
  assign eng_finished = eng_on && !hang && (ecnt == lat);
  assign eng_h0       = h0f(mode, eng_nonce);

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0]   base;
    int            num;
    logic [AW-1:0] ob;
    int            lat;
    int            mode;
    bit            hang;
    logic [31:0]   bn;
    logic [31:0]   bh;
    bit            to;
  } vec_t;

  wr_t         wq[$];
  logic [31:0] nq[$];
  int checks = 0, failures = 0;
  int done_cnt, on_cycles, wr_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic run_start(input logic [31:0] b, input int n, input logic [AW-1:0] ob,
                           output int k);
    @(posedge clk); #1;
    base_nonce = b; num_nonces = NW'(n); out_base = ob; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (!done && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) chk("done_wait_timeout", 32'd0, 32'd1);
  endtask

  vec_t v[6];

  initial begin
    int k;
    wr_t w;
    reset_n = 1'b0; start = 1'b0; base_nonce = '0; num_nonces = '0; out_base = '0;

    v[0] = '{32'd5,          3, 16'h0010, 10, 0, 1'b0, 32'd7,          32'hFFFF_FFF8, 1'b0};
    v[1] = '{32'h0000_1234,  0, 16'h0020,  4, 0, 1'b0, 32'd0,          32'hFFFF_FFFF, 1'b0};
    v[2] = '{32'hFFFF_FFFF,  2, 16'hFFFF,  0, 1, 1'b0, 32'hFFFF_FFFF,  32'h0000_1234, 1'b0};
    v[3] = '{32'd0,          2, 16'h0030,  0, 0, 1'b1, 32'd0,          32'hFFFF_FFFF, 1'b1};
    v[4] = '{32'd100,        4, 16'h0200,  3, 2, 1'b0, 32'd102,        32'h0000_0064, 1'b0};
    v[5] = '{32'h8000_0000,  5, 16'h0000,  1, 0, 1'b0, 32'h8000_0004,  32'h7FFF_FFFB, 1'b0};

    // Monitor/scoreboard lives in this block so the counters have one writer.
    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          if (eng_clr && eng_on) chk("clr_on_overlap", 32'd1, 32'd0);
          if (eng_on) on_cycles++;
          if (done) done_cnt++;
          if (eng_clr) begin
            if (nq.size() == 0) chk("unexpected_clr", 32'd1, 32'd0);
            else chk("eng_nonce", eng_nonce, nq.pop_front());
          end
          if (mem_we) begin
            wr_cnt++;
            if (wq.size() == 0) chk("unexpected_write", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            else begin
              w = wq.pop_front();
              chk("mem_addr", {16'h0, mem_addr}, {16'h0, w.addr});
              chk("mem_wdata", mem_wdata, w.data);
            end
          end
        end
      end
    join_none

    #12;
    chk("rst_best_h0", best_h0, 32'hFFFF_FFFF);
    chk("rst_outs", {busy, done, timeout_err, mem_we, eng_on, eng_clr}, 32'd0);
    chk("rst_best_nonce", best_nonce, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    foreach (v[i]) begin
      lat = v[i].lat; mode = v[i].mode; hang = v[i].hang;
      done_cnt = 0; on_cycles = 0; wr_cnt = 0;
      if (v[i].hang) nq.push_back(v[i].base);
      else for (int j = 0; j < v[i].num; j++) begin
        nq.push_back(v[i].base + 32'(j));
        wq.push_back('{v[i].ob + AW'(j), h0f(v[i].mode, v[i].base + 32'(j))});
      end
      run_start(v[i].base, v[i].num, v[i].ob, k);
      if (v[i].num == 0) chk("zero_done_latency_ok", 32'(k <= 2), 32'd1);
      @(posedge clk); @(posedge clk); #1;
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_on_cycles", i), on_cycles,
          v[i].hang ? TO : v[i].num * (v[i].lat + 1));
      chk($sformatf("v%0d_writes", i), wr_cnt, v[i].hang ? 0 : v[i].num);
      chk($sformatf("v%0d_best_nonce", i), best_nonce, v[i].bn);
      chk($sformatf("v%0d_best_h0", i), best_h0, v[i].bh);
      chk($sformatf("v%0d_timeout_err", i), {31'd0, timeout_err}, {31'd0, v[i].to});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_queues_left", i), wq.size() + nq.size(), 0);
    end

    // start pulsed mid-RUN must not disturb the sweep in flight
    lat = 5; mode = 0; hang = 1'b0; done_cnt = 0; on_cycles = 0; wr_cnt = 0;
    for (int j = 0; j < 2; j++) begin
      nq.push_back(32'd20 + 32'(j));
      wq.push_back('{16'h0040 + AW'(j), ~(32'd20 + 32'(j))});
    end
    @(posedge clk); #1;
    base_nonce = 32'd20; num_nonces = NW'(2); out_base = 16'h0040; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (!eng_on && k < 50) begin @(posedge clk); #1; k++; end
    chk("seqA_reached_run", {31'd0, eng_on}, 32'd1);
    @(posedge clk); #1;
    base_nonce = 32'd999; num_nonces = NW'(50); out_base = 16'h0900; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (!done && k < 500) begin @(posedge clk); #1; k++; end
    @(posedge clk); @(posedge clk); #1;
    chk("seqA_done_cnt", done_cnt, 1);
    chk("seqA_writes", wr_cnt, 2);
    chk("seqA_best_nonce", best_nonce, 32'd21);
    chk("seqA_queues_left", wq.size() + nq.size(), 0);

    // reset mid-RUN: outputs drop at once and the sweep never writes
    lat = 10; done_cnt = 0; wr_cnt = 0;
    nq.push_back(32'd7);
    @(posedge clk); #1;
    base_nonce = 32'd7; num_nonces = NW'(3); out_base = 16'h0050; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (!eng_on && k < 50) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    chk("seqB_eng_on", {31'd0, eng_on}, 32'd0);
    chk("seqB_busy", {31'd0, busy}, 32'd0);
    chk("seqB_best_h0", best_h0, 32'hFFFF_FFFF);
    chk("seqB_eng_nonce", eng_nonce, 32'd0);
    chk("seqB_mem_addr", {16'h0, mem_addr}, 32'd0);
    chk("seqB_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #2; reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("seqB_no_write", wr_cnt, 0);
    chk("seqB_no_done", done_cnt, 0);
    chk("seqB_idle", {31'd0, busy}, 32'd0);
    chk("seqB_queues_left", wq.size() + nq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
